// File: rtl/matrix_mem_responder_if.sv
// Bundle of matrix_mul stream signals and host load/readback signals for matrix_mem_responder.
// The slave modport is the responder's view; master is the driver side (matrix_mul plus host).
interface matrix_mem_responder_if #(
  parameter int DW = 16,
  parameter int AW = 6
);
  logic [3:0]    sizes;
  logic          ren;
  logic          raddr;
  logic [DW-1:0] rdata;
  logic          wen;
  logic [DW-1:0] wdata;
  logic          finish;
  logic          ld_en;
  logic          ld_sel;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          c_clr;
  logic [AW-1:0] c_rd_addr;
  logic [DW-1:0] c_rd_data;
  logic [AW:0]   c_cnt;
  logic          c_done;
  logic          busy;
  logic          ovf_err;
  logic          cfg_err;

  modport master (
    output sizes, ren, raddr, wen, wdata, finish,
    output ld_en, ld_sel, ld_addr, ld_data, c_clr, c_rd_addr,
    input  rdata, c_rd_data, c_cnt, c_done, busy, ovf_err, cfg_err
  );

  modport slave (
    input  sizes, ren, raddr, wen, wdata, finish,
    input  ld_en, ld_sel, ld_addr, ld_data, c_clr, c_rd_addr,
    output rdata, c_rd_data, c_cnt, c_done, busy, ovf_err, cfg_err
  );
endinterface

// File: rtl/matrix_mem_responder.sv
// Memory-side responder for matrix_mul: streams operand A/B bursts on rdata and captures the
// result stream into C; a host port loads A/B and reads C back.
module matrix_mem_responder #(
  parameter int DW   = 16,
  parameter int MAXN = 6,
  parameter int AW   = 6
) (
  input logic                   clk,
  input logic                   rstn,
  matrix_mem_responder_if.slave bus
);
  localparam int Depth = MAXN * MAXN;

  typedef logic [AW:0] cnt_t;
  localparam cnt_t MaxNC  = cnt_t'(MAXN);
  localparam cnt_t DepthC = cnt_t'(Depth);
  localparam cnt_t One    = cnt_t'(1);

  typedef enum logic [1:0] {IDLE, SEND, DONE_RD} state_e;

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  cnt_t          tot_q, tot_d;
  cnt_t          idx_q, idx_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          cfgErr_q, cfgErr_d;
  cnt_t          cCnt_q, cCnt_d;
  logic          cDone_q, cDone_d;
  logic          ovfErr_q, ovfErr_d;
  logic [DW-1:0] cRdData_q, cRdData_d;

  logic [DW-1:0] memA [Depth];
  logic [DW-1:0] memB [Depth];
  logic [DW-1:0] memC [Depth];

  cnt_t          nEff;
  cnt_t          total;
  cnt_t          cBase;
  logic          ldValid;
  logic          cWrEn;
  logic [AW-1:0] cWrAddr;

  assign nEff  = (cnt_t'(bus.sizes) > MaxNC) ? MaxNC : cnt_t'(bus.sizes);
  assign total = nEff * nEff;

  // Read-burst FSM: word 0 is fetched on the starting edge, so word k lands on rdata k edges later.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    tot_d    = tot_q;
    idx_d    = idx_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    cfgErr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.ren) begin
          if (bus.sizes == 4'd0) begin
            cfgErr_d = 1'b1;
          end else begin
            sel_d   = bus.raddr;
            tot_d   = total;
            rdata_d = bus.raddr ? memB[0] : memA[0];
            idx_d   = One;
            busy_d  = 1'b1;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (!bus.ren) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q < tot_q) begin
          rdata_d = sel_q ? memB[idx_q[AW-1:0]] : memA[idx_q[AW-1:0]];
          idx_d   = idx_q + One;
        end else begin
          busy_d  = 1'b0;
          state_d = DONE_RD;
        end
      end
      DONE_RD: begin
        busy_d = 1'b0;
        if (!bus.ren) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result capture and host side; a same-edge clear is applied before the incoming word is counted.
  always_comb begin
    cBase     = bus.c_clr ? '0 : cCnt_q;
    cCnt_d    = cBase;
    cDone_d   = bus.c_clr ? 1'b0 : cDone_q;
    ovfErr_d  = bus.c_clr ? 1'b0 : ovfErr_q;
    cWrEn     = 1'b0;
    cWrAddr   = cBase[AW-1:0];
    ldValid   = 1'b0;
    cRdData_d = '0;
    if (bus.wen) begin
      if ((cBase == tot_q) || (cBase == DepthC)) begin
        ovfErr_d = 1'b1;
      end else begin
        cWrEn  = rstn;
        cCnt_d = cBase + One;
        if ((cBase + One) == tot_q) cDone_d = 1'b1;
      end
    end
    if (bus.finish) cDone_d = 1'b1;
    if (bus.ld_en) begin
      if ({1'b0, bus.ld_addr} < DepthC) ldValid = rstn;
      else                              ovfErr_d = 1'b1;
    end
    if ({1'b0, bus.c_rd_addr} < DepthC) cRdData_d = memC[bus.c_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      tot_q     <= DepthC;
      idx_q     <= '0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      cfgErr_q  <= 1'b0;
      cCnt_q    <= '0;
      cDone_q   <= 1'b0;
      ovfErr_q  <= 1'b0;
      cRdData_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tot_q     <= tot_d;
      idx_q     <= idx_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
      cfgErr_q  <= cfgErr_d;
      cCnt_q    <= cCnt_d;
      cDone_q   <= cDone_d;
      ovfErr_q  <= ovfErr_d;
      cRdData_q <= cRdData_d;
    end
  end

  // Storage is never cleared; a load colliding with the burst read returns the old word.
  always_ff @(posedge clk) begin
    if (ldValid) begin
      if (bus.ld_sel) memB[bus.ld_addr] <= bus.ld_data;
      else            memA[bus.ld_addr] <= bus.ld_data;
    end
    if (cWrEn) memC[cWrAddr] <= bus.wdata;
  end

  assign bus.rdata     = rdata_q;
  assign bus.c_rd_data = cRdData_q;
  assign bus.c_cnt     = cCnt_q;
  assign bus.c_done    = cDone_q;
  assign bus.busy      = busy_q;
  assign bus.ovf_err   = ovfErr_q;
  assign bus.cfg_err   = cfgErr_q;
endmodule

// File: tb/tb_matrix_mem_responder.sv
// Self-checking bench for matrix_mem_responder: directed scenarios plus randomized bursts and
// capture sessions, compared against an array/counter model of the storage rules.
module tb_matrix_mem_responder;
  localparam int DW    = 16;
  localparam int MAXN  = 6;
  localparam int AW    = 6;
  localparam int DEPTH = MAXN * MAXN;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  matrix_mem_responder_if #(.DW(DW), .AW(AW)) bus ();

  matrix_mem_responder #(.DW(DW), .MAXN(MAXN), .AW(AW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  logic [DW-1:0] refM [2][DEPTH];
  logic [DW-1:0] refC [DEPTH];
  int            refCnt;
  int            refTot;
  bit            refDone;
  bit            refOvf;
  logic [DW-1:0] lastWord;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    bus.sizes     = 4'd0;
    bus.ren       = 1'b0;
    bus.raddr     = 1'b0;
    bus.wen       = 1'b0;
    bus.wdata     = '0;
    bus.finish    = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_sel    = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.c_clr     = 1'b0;
    bus.c_rd_addr = '0;
  endtask

  // Updates the storage-side model from the inputs about to be sampled, then advances one edge.
  task automatic applyStimulus();
    if (bus.c_clr) begin
      refCnt  = 0;
      refDone = 1'b0;
      refOvf  = 1'b0;
    end
    if (bus.wen) begin
      if (refCnt == refTot || refCnt == DEPTH) refOvf = 1'b1;
      else begin
        refC[refCnt] = bus.wdata;
        refCnt++;
        if (refCnt == refTot) refDone = 1'b1;
      end
    end
    if (bus.finish) refDone = 1'b1;
    if (bus.ld_en) begin
      if (int'(bus.ld_addr) < DEPTH) refM[bus.ld_sel][bus.ld_addr] = bus.ld_data;
      else refOvf = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input bit sel, input int addr, input logic [DW-1:0] data);
    bus.ld_en   = 1'b1;
    bus.ld_sel  = sel;
    bus.ld_addr = AW'(addr);
    bus.ld_data = data;
    applyStimulus();
    bus.ld_en   = 1'b0;
  endtask

  task automatic readC(input int addr);
    logic [DW-1:0] exp;
    bus.c_rd_addr = AW'(addr);
    applyStimulus();
    exp = (addr < DEPTH) ? refC[addr] : '0;
    checkOutput($sformatf("c_rd_data[%0d]", addr), 32'(bus.c_rd_data), 32'(exp));
  endtask

  task automatic checkCapture(input string tag);
    checkOutput({tag, " c_cnt"},   32'(bus.c_cnt),   32'(refCnt));
    checkOutput({tag, " c_done"},  32'(bus.c_done),  32'(refDone));
    checkOutput({tag, " ovf_err"}, 32'(bus.ovf_err), 32'(refOvf));
  endtask

  // Holds ren for holdEdges edges, then releases it; expects word k after the k-th edge,
  // or the last word with busy low once the burst is exhausted.
  task automatic runBurst(input bit sel, input int sz, input int holdEdges, input bit wobble);
    int n;
    int total;
    n     = (sz > MAXN) ? MAXN : sz;
    total = n * n;
    bus.ren   = 1'b1;
    bus.raddr = sel;
    bus.sizes = 4'(sz);
    if (total == 0) begin
      applyStimulus();
      checkOutput("cfg_err on zero size", 32'(bus.cfg_err), 32'd1);
      checkOutput("busy on zero size", 32'(bus.busy), 32'd0);
      checkOutput("rdata hold on zero size", 32'(bus.rdata), 32'(lastWord));
      bus.ren = 1'b0;
      applyStimulus();
      checkOutput("cfg_err one cycle", 32'(bus.cfg_err), 32'd0);
      return;
    end
    refTot = total;
    for (int c = 0; c < holdEdges; c++) begin
      applyStimulus();
      if (wobble) begin
        bus.raddr = 1'($urandom_range(0, 1));
        bus.sizes = 4'($urandom_range(0, 15));
      end
      if (c < total) lastWord = refM[sel][c];
      checkOutput($sformatf("rdata sel%0d word%0d", sel, c), 32'(bus.rdata), 32'(lastWord));
      checkOutput($sformatf("busy cycle%0d", c + 1), 32'(bus.busy), 32'(c < total));
      if (c == 0) checkOutput("cfg_err quiet", 32'(bus.cfg_err), 32'd0);
    end
    bus.ren = 1'b0;
    applyStimulus();
    checkOutput("busy after release", 32'(bus.busy), 32'd0);
    checkOutput("rdata hold after release", 32'(bus.rdata), 32'(lastWord));
  endtask

  initial begin
    idleInputs();
    rstn     = 1'b0;
    lastWord = '0;
    refCnt   = 0;
    refTot   = DEPTH;
    refDone  = 1'b0;
    refOvf   = 1'b0;
    for (int i = 0; i < DEPTH; i++) refC[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rdata", 32'(bus.rdata), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset cfg_err", 32'(bus.cfg_err), 32'd0);
    checkOutput("reset c_rd_data", 32'(bus.c_rd_data), 32'd0);
    checkCapture("reset");
    rstn = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      loadWord(1'b0, i, DW'(i + 1));
      loadWord(1'b1, i, DW'(DEPTH - i));
    end

    runBurst(1'b0, 6, 37, 1'b0);
    runBurst(1'b1, 2, 7, 1'b1);
    runBurst(1'b0, 6, 6, 1'b0);
    runBurst(1'b0, 6, 3, 1'b0);
    runBurst(1'b0, 9, 37, 1'b0);
    runBurst(1'b1, 0, 1, 1'b0);

    bus.c_clr = 1'b1;
    applyStimulus();
    bus.c_clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.wen   = 1'b1;
      bus.wdata = DW'(-100 + i);
      applyStimulus();
      if (i == DEPTH - 2) checkCapture("capture before last");
    end
    bus.wen = 1'b0;
    checkCapture("capture full");
    bus.wen   = 1'b1;
    bus.wdata = 16'h1234;
    applyStimulus();
    bus.wen = 1'b0;
    checkCapture("capture overflow");
    for (int a = 0; a < DEPTH; a++) readC(a);
    readC(50);

    bus.c_clr = 1'b1;
    bus.wen   = 1'b1;
    bus.wdata = 16'h7FFF;
    applyStimulus();
    bus.c_clr = 1'b0;
    bus.wen   = 1'b0;
    checkCapture("clear with wen");
    readC(0);
    bus.finish = 1'b1;
    applyStimulus();
    bus.finish = 1'b0;
    checkCapture("finish pulse");
    loadWord(1'b0, 40, 16'hDEAD);
    checkCapture("load out of range");

    bus.ren   = 1'b1;
    bus.raddr = 1'b0;
    bus.sizes = 4'd6;
    for (int c = 0; c <= 10; c++) applyStimulus();
    checkOutput("rdata before reset", 32'(bus.rdata), 32'(refM[0][10]));
    rstn = 1'b0;
    @(posedge clk);
    #1;
    refCnt   = 0;
    refDone  = 1'b0;
    refOvf   = 1'b0;
    lastWord = '0;
    checkOutput("mid-burst reset rdata", 32'(bus.rdata), 32'd0);
    checkOutput("mid-burst reset busy", 32'(bus.busy), 32'd0);
    checkCapture("mid-burst reset");
    rstn    = 1'b1;
    bus.ren = 1'b0;
    applyStimulus();
    runBurst(1'b0, 6, 37, 1'b0);

    for (int iter = 0; iter < 20; iter++) begin
      for (int k = 0; k < 4; k++) begin
        loadWord(1'($urandom_range(0, 1)), int'($urandom_range(0, 39)), DW'($urandom));
      end
      runBurst(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
               int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
      bus.c_clr = 1'b1;
      for (int k = 0; k < int'($urandom_range(1, 40)); k++) begin
        bus.wen    = 1'($urandom_range(0, 3) != 0);
        bus.wdata  = DW'($urandom);
        bus.finish = 1'($urandom_range(0, 15) == 0);
        applyStimulus();
        bus.c_clr = 1'b0;
        checkCapture($sformatf("random capture %0d.%0d", iter, k));
      end
      bus.wen    = 1'b0;
      bus.finish = 1'b0;
      bus.c_clr  = 1'b0;
      readC(int'($urandom_range(0, DEPTH - 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
